parking_lot_monitor: RTL and testbench
======================================

Name: parking_lot_monitor

Overview:
- Parametrised multi-gate successor to the single-gate parking occupancy counter.
- Each of NUM_GATES gates has a two-photosensor pair (a outside, b inside), already debounced upstream, and its own direction-decoding FSM.
- All gate events merge into one saturating occupancy counter with capacity limit, full/empty flags and sticky error flags.
- A registered BCD copy of the count feeds the seven-segment display mux.

Parameters:
- NUM_GATES, 2, number of independent entrance/exit gates (1..8).
- CAPACITY, 99, maximum occupancy; count saturates here.
- NUM_DIGITS, 2, BCD digits on bcd_out; 10^NUM_DIGITS must exceed CAPACITY.
- CW, $clog2(CAPACITY+1), count width (derived, not overridden).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- a  in  NUM_GATES  outer sensor per gate, 1 = beam blocked.
- b  in  NUM_GATES  inner sensor per gate, 1 = beam blocked.
- enter  out  NUM_GATES  1-cycle pulse per completed entry, per gate.
- exit  out  NUM_GATES  1-cycle pulse per completed exit, per gate.
- count  out  CW  current occupancy.
- full  out  1  count == CAPACITY.
- empty  out  1  count == 0.
- bcd_out  out  4*NUM_DIGITS  BCD of count, digit 0 in bits [3:0].
- ovf_err  out  1  sticky: an entry was dropped at saturation.
- unf_err  out  1  sticky: an exit was dropped at zero.

Behaviour:
- Reset: all gate FSMs go to IDLE; enter/exit = 0, count = 0, full = 0, empty = 1, bcd_out = 0, ovf_err = 0, unf_err = 0.
- Per-gate FSM, registered. Sensor code is {a,b}.
  - IDLE: 10 -> E1; 01 -> X1; 11 -> ERR; 00 -> stay.
  - E1: 11 -> E2; 00 -> IDLE (abort); 10 -> stay; 01 -> ERR.
  - E2: 01 -> E3; 10 -> E1 (back-up); 11 -> stay; 00 -> ERR.
  - E3: 00 -> IDLE with enter pulse; 11 -> E2; 01 -> stay; 10 -> ERR.
  - X1/X2/X3: mirror of E1/E2/E3 with a and b swapped; X3 -> IDLE on 00 pulses exit.
  - ERR: stay until 00, then IDLE; no pulse is ever generated from ERR.
- enter/exit are registered and asserted for exactly the one cycle after the final 00 is sampled.
- Counter:
  - Each cycle, E = popcount(enter) and X = popcount(exit).
  - next = count + E - X, computed signed at CW+4 bits.
  - If next > CAPACITY, count = CAPACITY and ovf_err is set.
  - If next < 0, count = 0 and unf_err is set.
  - Otherwise count = next.
  - Latency is 1 cycle from the enter/exit pulse to count.
  - Simultaneous enter and exit on different gates net out: E = X leaves count unchanged, and no error flag sets even when full or empty.
- full and empty are registered alongside count, with the same latency.
- bcd_out is a combinational binary-to-BCD conversion of count, registered, so it lags count by 1 cycle.
- ovf_err and unf_err clear only on reset.
- Asserting reset mid-sequence discards the partial gate transit; no pulse is emitted after reset releases until a fresh full sequence completes.

Optional Feature:
- Macro: PARKING_SEQ_ERR_CNT_EN.
- Defined:
  - Adds output port seq_err_cnt, 8 bits, reset 0.
  - Increments once on every gate FSM entry into ERR, summing all gates entering ERR in the same cycle.
  - Saturates at 255.
- Undefined: port absent, no counting logic; all other behaviour is identical.

Test Plan:
- Gate0, one step per cycle, {a,b} = 10, 11, 01, 00 -> enter[0] high 1 cycle after the final 00; count 0 -> 1 next cycle; bcd_out = 0x01 one cycle later; empty falls.
- Gate1 exit sequence 01, 11, 10, 00 starting from count = 1 -> exit[1] pulse; count = 0; empty = 1; unf_err stays 0.
- Gate0 runs 10, 11, 10, 00 (back-up then abort) -> no enter pulse, count unchanged. Gate0 jumps 00 to 11 -> ERR; no pulse until a later 00; seq_err_cnt = 1 when the macro is defined.
- Preload count to 98, then entries complete on gates 0 and 1 in the same cycle -> count = 99, full = 1, ovf_err = 1, bcd_out = 0x99.
- At count = 99, gate0 entry and gate1 exit complete in the same cycle -> count stays 99, no error flag. With count = 0, an exit completes -> count 0, unf_err = 1.
- Assert reset while gate0 is in E2 with count = 5 -> all outputs return to reset values immediately; after release, a lone 01, 00 from gate0 produces no pulse.

Source files
------------

// File: rtl/parking_lot_monitor.sv
`default_nettype none
// ============================================================================
// Module   : parking_lot_monitor
// Purpose  : Multi-gate parking occupancy monitor. Each gate decodes its
//            debounced photosensor pair (a = outside, b = inside) into entry
//            and exit events. The events merge into one saturating occupancy
//            counter that has full/empty flags and sticky overflow/underflow
//            flags. A registered BCD copy of the count drives the display mux.
// Ports    : clk         - system clock
//            reset       - asynchronous, active-high reset
//            a, b        - per-gate sensor beams, 1 = blocked
//            enter, exit - per-gate 1-cycle completion pulses
//            count       - current occupancy
//            full, empty - count == CAPACITY / count == 0
//            bcd_out     - BCD of count, digit 0 in bits [3:0], lags count by 1
//            ovf_err     - sticky, an entry was dropped at saturation
//            unf_err     - sticky, an exit was dropped at zero
//            seq_err_cnt - (PARKING_SEQ_ERR_CNT_EN only) saturating count of
//                          gate FSM entries into the error state
// Option   : define PARKING_SEQ_ERR_CNT_EN to add the seq_err_cnt port
// Revision : 1.0 - initial release
// ============================================================================
module parking_lot_monitor #(
    parameter int NUM_GATES  = 2,
    parameter int CAPACITY   = 99,
    parameter int NUM_DIGITS = 2,
    localparam int CW        = $clog2(CAPACITY + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_GATES-1:0]    a,
    input  logic [NUM_GATES-1:0]    b,
    output logic [NUM_GATES-1:0]    enter,
    output logic [NUM_GATES-1:0]    exit,
    output logic [CW-1:0]           count,
    output logic                    full,
    output logic                    empty,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic                    ovf_err,
    output logic                    unf_err
`ifdef PARKING_SEQ_ERR_CNT_EN
    ,
    output logic [7:0]              seq_err_cnt
`endif
);

    // Sum width leaves headroom so count + E - X can go negative or above
    // CAPACITY without wrapping.
    localparam int c_NW = CW + 4;
    localparam logic signed [c_NW-1:0] c_CAP_S = c_NW'(CAPACITY);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_E1   = 3'd1,
        S_E2   = 3'd2,
        S_E3   = 3'd3,
        S_X1   = 3'd4,
        S_X2   = 3'd5,
        S_X3   = 3'd6,
        S_ERR  = 3'd7
    } state_t;

    logic [NUM_GATES-1:0] w_enter;
    logic [NUM_GATES-1:0] w_exit;
    logic [NUM_GATES-1:0] w_err_entry;

    // ------------------------------------------------------------------
    // Per-gate direction decoder
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_GATES; g++) begin : g_gate
        state_t     state_q, state_d;
        logic       ent_q, ent_d;
        logic       ext_q, ext_d;
        logic [1:0] w_code;

        assign w_code = {a[g], b[g]};

        always_comb begin
            state_d = state_q;
            ent_d   = 1'b0;
            ext_d   = 1'b0;
            case (state_q)
                S_IDLE: case (w_code)
                    2'b10:   state_d = S_E1;
                    2'b01:   state_d = S_X1;
                    2'b11:   state_d = S_ERR;
                    default: state_d = S_IDLE;
                endcase
                S_E1: case (w_code)
                    2'b11:   state_d = S_E2;
                    2'b00:   state_d = S_IDLE;
                    2'b01:   state_d = S_ERR;
                    default: state_d = S_E1;
                endcase
                S_E2: case (w_code)
                    2'b01:   state_d = S_E3;
                    2'b10:   state_d = S_E1;
                    2'b00:   state_d = S_ERR;
                    default: state_d = S_E2;
                endcase
                S_E3: case (w_code)
                    2'b00: begin
                        state_d = S_IDLE;
                        ent_d   = 1'b1;
                    end
                    2'b11:   state_d = S_E2;
                    2'b10:   state_d = S_ERR;
                    default: state_d = S_E3;
                endcase
                // Exit path: entry path with a and b swapped.
                S_X1: case (w_code)
                    2'b11:   state_d = S_X2;
                    2'b00:   state_d = S_IDLE;
                    2'b10:   state_d = S_ERR;
                    default: state_d = S_X1;
                endcase
                S_X2: case (w_code)
                    2'b10:   state_d = S_X3;
                    2'b01:   state_d = S_X1;
                    2'b00:   state_d = S_ERR;
                    default: state_d = S_X2;
                endcase
                S_X3: case (w_code)
                    2'b00: begin
                        state_d = S_IDLE;
                        ext_d   = 1'b1;
                    end
                    2'b11:   state_d = S_X2;
                    2'b01:   state_d = S_ERR;
                    default: state_d = S_X3;
                endcase
                S_ERR:   state_d = (w_code == 2'b00) ? S_IDLE : S_ERR;
                default: state_d = S_IDLE;
            endcase
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= S_IDLE;
                ent_q   <= 1'b0;
                ext_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                ent_q   <= ent_d;
                ext_q   <= ext_d;
            end
        end

        assign w_enter[g]     = ent_q;
        assign w_exit[g]      = ext_q;
        assign w_err_entry[g] = (state_d == S_ERR) && (state_q != S_ERR);
    end

    // ------------------------------------------------------------------
    // Occupancy counter
    // ------------------------------------------------------------------
    logic [CW-1:0]           count_q, count_d;
    logic                    full_q, full_d;
    logic                    empty_q, empty_d;
    logic                    ovf_q, ovf_d;
    logic                    unf_q, unf_d;
    logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
    logic [3:0]              w_e_cnt;
    logic [3:0]              w_x_cnt;
    logic signed [c_NW-1:0]  w_next;

    always_comb begin
        w_e_cnt = '0;
        w_x_cnt = '0;
        for (int g = 0; g < NUM_GATES; g++) begin
            w_e_cnt = w_e_cnt + 4'(w_enter[g]);
            w_x_cnt = w_x_cnt + 4'(w_exit[g]);
        end
        w_next  = c_NW'(count_q) + c_NW'(w_e_cnt) - c_NW'(w_x_cnt);

        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (w_next > c_CAP_S) begin
            count_d = CW'(CAPACITY);
            ovf_d   = 1'b1;
        end else if (w_next < 0) begin
            count_d = '0;
            unf_d   = 1'b1;
        end else begin
            count_d = w_next[CW-1:0];
        end
        full_d  = (count_d == CW'(CAPACITY));
        empty_d = (count_d == '0);
    end

    // Shift-and-add-3 conversion of the registered count; the result is
    // registered again, so bcd_out trails count by one cycle.
    always_comb begin
        bcd_d = '0;
        for (int i = CW - 1; i >= 0; i--) begin
            for (int d = 0; d < NUM_DIGITS; d++) begin
                if (bcd_d[4*d +: 4] >= 4'd5) begin
                    bcd_d[4*d +: 4] = bcd_d[4*d +: 4] + 4'd3;
                end
            end
            bcd_d = {bcd_d[4*NUM_DIGITS-2:0], count_q[i]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            bcd_q   <= '0;
        end else begin
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            bcd_q   <= bcd_d;
        end
    end

    assign enter   = w_enter;
    assign exit    = w_exit;
    assign count   = count_q;
    assign full    = full_q;
    assign empty   = empty_q;
    assign bcd_out = bcd_q;
    assign ovf_err = ovf_q;
    assign unf_err = unf_q;

`ifdef PARKING_SEQ_ERR_CNT_EN
    // ------------------------------------------------------------------
    // Saturating count of gate FSM entries into the error state
    // ------------------------------------------------------------------
    logic [7:0] seq_err_q, seq_err_d;
    logic [8:0] w_seq_sum;

    always_comb begin
        w_seq_sum = {1'b0, seq_err_q};
        for (int g = 0; g < NUM_GATES; g++) begin
            w_seq_sum = w_seq_sum + 9'(w_err_entry[g]);
        end
        seq_err_d = w_seq_sum[8] ? 8'hFF : w_seq_sum[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seq_err_q <= '0;
        end else begin
            seq_err_q <= seq_err_d;
        end
    end

    assign seq_err_cnt = seq_err_q;
`else
    // Error-state entries are only consumed by the optional counter.
    logic w_unused_err;
    assign w_unused_err = ^w_err_entry;
`endif

endmodule
`default_nettype wire

// File: tb/tb_parking_lot_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_parking_lot_monitor
// Purpose  : Self-checking bench for parking_lot_monitor. A behavioural model
//            describes each gate as a position along its legal sensor path,
//            keeps the occupancy as a plain integer and derives the BCD
//            digits arithmetically. The model is compared against every
//            output each cycle. Stimulus is directed scenarios followed by
//            random gate scripts.
// Option   : define PARKING_SEQ_ERR_CNT_EN to also check seq_err_cnt
// Revision : 1.0 - initial release
// ============================================================================
module tb_parking_lot_monitor;

    localparam int NG  = 2;
    localparam int CAP = 99;
    localparam int ND  = 2;
    localparam int CW  = $clog2(CAP + 1);

    logic            clk = 1'b0;
    logic            reset;
    logic [NG-1:0]   a, b;
    logic [NG-1:0]   enter, exit;
    logic [CW-1:0]   count;
    logic            full, empty, ovf_err, unf_err;
    logic [4*ND-1:0] bcd_out;
`ifdef PARKING_SEQ_ERR_CNT_EN
    logic [7:0]      seq_err_cnt;
`endif

    parking_lot_monitor #(
        .NUM_GATES  (NG),
        .CAPACITY   (CAP),
        .NUM_DIGITS (ND)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .a       (a),
        .b       (b),
        .enter   (enter),
        .exit    (exit),
        .count   (count),
        .full    (full),
        .empty   (empty),
        .bcd_out (bcd_out),
        .ovf_err (ovf_err),
        .unf_err (unf_err)
`ifdef PARKING_SEQ_ERR_CNT_EN
        ,
        .seq_err_cnt (seq_err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    int      cnt_m, bcd_cnt_m, seq_m;
    bit      full_m, empty_m, ovf_m, unf_m;
    bit [NG-1:0] ent_m, ext_m;
    int      pos [NG];   // 0 = idle, 1..3 = steps taken along the path
    int      dir [NG];   // 0 = entering, 1 = leaving
    bit      err [NG];

    // Legal path of sensor codes {a,b}: entry 00,10,11,01,00; exit mirrors it.
    function automatic int path_code(input int d, input int p);
        if (d == 0) begin
            case (p) 1: return 2; 2: return 3; 3: return 1; default: return 0; endcase
        end else begin
            case (p) 1: return 1; 2: return 3; 3: return 2; default: return 0; endcase
        end
    endfunction

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        int          scale;
        r     = 0;
        scale = 1;
        for (int d = 0; d < ND; d++) begin
            r     = r | (32'((v / scale) % 10) << (4 * d));
            scale = scale * 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        cnt_m = 0; bcd_cnt_m = 0; seq_m = 0;
        full_m = 0; empty_m = 1; ovf_m = 0; unf_m = 0;
        ent_m = '0; ext_m = '0;
        for (int g = 0; g < NG; g++) begin
            pos[g] = 0; dir[g] = 0; err[g] = 0;
        end
    endtask

    task automatic model_step();
        int e, x, nxt, c, newerr;
        e = 0; x = 0; newerr = 0;
        bcd_cnt_m = cnt_m;
        for (int g = 0; g < NG; g++) begin
            e += int'(ent_m[g]);
            x += int'(ext_m[g]);
        end
        nxt = cnt_m + e - x;
        if (nxt > CAP) begin
            cnt_m = CAP; ovf_m = 1;
        end else if (nxt < 0) begin
            cnt_m = 0; unf_m = 1;
        end else begin
            cnt_m = nxt;
        end
        full_m  = (cnt_m == CAP);
        empty_m = (cnt_m == 0);
        for (int g = 0; g < NG; g++) begin
            c = int'({a[g], b[g]});
            ent_m[g] = 0;
            ext_m[g] = 0;
            if (err[g]) begin
                if (c == 0) err[g] = 0;
            end else if (pos[g] == 0) begin
                if (c == 2) begin dir[g] = 0; pos[g] = 1; end
                else if (c == 1) begin dir[g] = 1; pos[g] = 1; end
                else if (c == 3) begin err[g] = 1; newerr++; end
            end else if (c == path_code(dir[g], pos[g])) begin
                // holding the same code keeps the position
            end else if (c == path_code(dir[g], pos[g] + 1)) begin
                if (pos[g] == 3) begin
                    pos[g] = 0;
                    if (dir[g] == 0) ent_m[g] = 1; else ext_m[g] = 1;
                end else begin
                    pos[g]++;
                end
            end else if (c == path_code(dir[g], pos[g] - 1)) begin
                pos[g]--;
            end else begin
                pos[g] = 0; err[g] = 1; newerr++;
            end
        end
        seq_m = (seq_m + newerr > 255) ? 255 : seq_m + newerr;
    endtask

    always @(posedge clk) begin
        if (reset) model_reset();
        else       model_step();
    end

    task automatic check_all();
        chk("enter", 32'(enter), 32'(ent_m));
        chk("exit", 32'(exit), 32'(ext_m));
        chk("count", 32'(count), 32'(cnt_m));
        chk("full", 32'(full), 32'(full_m));
        chk("empty", 32'(empty), 32'(empty_m));
        chk("bcd_out", 32'(bcd_out), to_bcd(bcd_cnt_m));
        chk("ovf_err", 32'(ovf_err), 32'(ovf_m));
        chk("unf_err", 32'(unf_err), 32'(unf_m));
`ifdef PARKING_SEQ_ERR_CNT_EN
        chk("seq_err_cnt", 32'(seq_err_cnt), 32'(seq_m));
`endif
    endtask

    // One cycle: check outputs of the previous edge, then apply gate codes.
    task automatic cyc(input logic [1:0] c0, input logic [1:0] c1);
        @(negedge clk);
        check_all();
        a = {c1[1], c0[1]};
        b = {c1[0], c0[0]};
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(2'b00, 2'b00);
    endtask

    task automatic both_enter();
        cyc(2'b10, 2'b10); cyc(2'b11, 2'b11); cyc(2'b01, 2'b01); cyc(2'b00, 2'b00);
    endtask

    // Random per-gate scripts of four codes.
    int scr [NG][4];
    int six [NG];

    task automatic rand_cycle(input int entry_weight);
        logic [1:0] cd [NG];
        int r;
        for (int g = 0; g < NG; g++) begin
            if (six[g] >= 4) begin
                r = int'($urandom_range(0, 9));
                six[g] = 0;
                if (r < entry_weight) begin
                    scr[g][0] = 2; scr[g][1] = 3; scr[g][2] = 1; scr[g][3] = 0;
                end else if (r < 8) begin
                    scr[g][0] = 1; scr[g][1] = 3; scr[g][2] = 2; scr[g][3] = 0;
                end else if (r == 8) begin
                    scr[g][0] = 2; scr[g][1] = 3; scr[g][2] = 2; scr[g][3] = 0;
                end else begin
                    scr[g][0] = int'($urandom_range(0, 3));
                    scr[g][1] = int'($urandom_range(0, 3));
                    scr[g][2] = 0; scr[g][3] = 0;
                end
            end
            cd[g] = 2'(scr[g][six[g]]);
            // Occasionally hold the current code for an extra cycle.
            if ($urandom_range(0, 3) != 0) six[g]++;
        end
        cyc(cd[0], cd[1]);
    endtask

    initial begin
        reset = 1'b1;
        a = '0;
        b = '0;
        model_reset();
        for (int g = 0; g < NG; g++) six[g] = 4;
        repeat (2) @(negedge clk);
        check_all();
        reset = 1'b0;

        // Entry on gate 0.
        cyc(2'b10, 2'b00); cyc(2'b11, 2'b00); cyc(2'b01, 2'b00); cyc(2'b00, 2'b00);
        idle(3);
        chk("entry_count", 32'(count), 32'd1);
        chk("entry_bcd", 32'(bcd_out), 32'h01);

        // Exit on gate 1 back to zero.
        cyc(2'b00, 2'b01); cyc(2'b00, 2'b11); cyc(2'b00, 2'b10); cyc(2'b00, 2'b00);
        idle(3);
        chk("exit_empty", 32'(empty), 32'd1);

        // Back-up then abort, then an illegal jump into the error state.
        cyc(2'b10, 2'b00); cyc(2'b11, 2'b00); cyc(2'b10, 2'b00); cyc(2'b00, 2'b00);
        cyc(2'b11, 2'b00); cyc(2'b11, 2'b00); cyc(2'b01, 2'b00); cyc(2'b00, 2'b00);
        idle(3);

        // Exit at zero.
        cyc(2'b00, 2'b01); cyc(2'b00, 2'b11); cyc(2'b00, 2'b10); cyc(2'b00, 2'b00);
        idle(3);
        chk("underflow_flag", 32'(unf_err), 32'd1);

        // Five entries, then reset while gate 0 sits mid-entry.
        for (int i = 0; i < 5; i++) begin
            cyc(2'b10, 2'b00); cyc(2'b11, 2'b00); cyc(2'b01, 2'b00); cyc(2'b00, 2'b00);
        end
        idle(3);
        chk("pre_reset_count", 32'(count), 32'd5);
        cyc(2'b10, 2'b00); cyc(2'b11, 2'b00);
        @(negedge clk);
        check_all();
        reset = 1'b1;
        a = '0;
        b = '0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b0;
        cyc(2'b01, 2'b00); cyc(2'b00, 2'b00);
        idle(3);

        // Fill to 98, then two simultaneous entries overflow by one.
        for (int i = 0; i < 49; i++) both_enter();
        idle(3);
        chk("fill_count", 32'(count), 32'd98);
        both_enter();
        idle(3);
        chk("sat_count", 32'(count), 32'(CAP));
        chk("sat_full", 32'(full), 32'd1);
        chk("sat_ovf", 32'(ovf_err), 32'd1);
        chk("sat_bcd", 32'(bcd_out), 32'h99);

        // Entry on gate 0 and exit on gate 1 complete together while full.
        cyc(2'b10, 2'b01); cyc(2'b11, 2'b11); cyc(2'b01, 2'b10); cyc(2'b00, 2'b00);
        idle(3);
        chk("net_zero_count", 32'(count), 32'(CAP));

        // Random traffic: fill-biased phase, then drain-biased phase.
        for (int i = 0; i < 1500; i++) rand_cycle(6);
        for (int i = 0; i < 1500; i++) rand_cycle(2);
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
